laser_range_avg: RTL and testbench

LASER_RANGE_AVG -- requirements
Module: laser_range_avg

---
 rtl/laser_pkg.sv | 26 ++
 rtl/laser_shot_timer.sv | 40 ++++
 rtl/laser_range_avg.sv | 161 ++++++++++++++++
 tb/tb_laser_range_avg.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/laser_pkg.sv
// Shared definitions for the laser range averaging block: FSM encoding,
// default parameter values and a small width helper.
package laser_pkg;

  // Default configuration
  localparam int unsigned DEF_CNT_W      = 16;
  localparam int unsigned DEF_SHOTS_LOG2 = 2;
  localparam int unsigned DEF_PULSE_LEN  = 1;
  localparam int unsigned DEF_GAP_LEN    = 1;

  // Measurement sequencer states
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FIRE = 3'd1,
    ST_WAIT = 3'd2,
    ST_GAP  = 3'd3,
    ST_DONE = 3'd4,
    ST_ERR  = 3'd5
  } state_t;

  // Counter width able to index 0..n-1, never narrower than one bit
  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/laser_shot_timer.sv
// Round-trip counter for a single shot. Cleared while idle, counts while
// enabled, and flags when the count sits on the abandon threshold.
module laser_shot_timer
  import laser_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned TIMEOUT = (2 ** CNT_W) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  logic [CNT_W-1:0] count_nxt;

  // Next count: clear has priority over counting
  always_comb begin
    count_nxt = count;
    if (clear) begin
      count_nxt = '0;
    end else if (enable) begin
      count_nxt = count + CNT_W'(1);
    end
  end

  // Count register; expired is registered alongside so it tracks count exactly
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      expired <= 1'b0;
    end else begin
      count   <= count_nxt;
      expired <= (count_nxt == CNT_W'(TIMEOUT));
    end
  end

endmodule

// File: rtl/laser_range_avg.sv
// Laser rangefinder: on a button press fires 2**SHOTS_LOG2 shots, measures
// each round-trip time in clock cycles and reports the truncated average.
// A shot with no reflection by TIMEOUT aborts the whole measurement.
module laser_range_avg
  import laser_pkg::*;
#(
  parameter int unsigned CNT_W      = DEF_CNT_W,
  parameter int unsigned SHOTS_LOG2 = DEF_SHOTS_LOG2,
  parameter int unsigned PULSE_LEN  = DEF_PULSE_LEN,
  parameter int unsigned GAP_LEN    = DEF_GAP_LEN,
  parameter int unsigned TIMEOUT    = (2 ** CNT_W) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic             laser_reflect,
  output logic             act_laser,
  output logic [CNT_W-1:0] data,
  output logic             valid,
  output logic             timeout_err,
  output logic             busy
);

  localparam int unsigned ACC_W  = CNT_W + SHOTS_LOG2;
  localparam int unsigned NSHOTS = 2 ** SHOTS_LOG2;
  localparam int unsigned IDX_W  = min1_clog2(NSHOTS);
  localparam int unsigned GAP_W  = min1_clog2(GAP_LEN);

  state_t           state;
  logic             btn_q;
  logic             btn_armed;
  logic [IDX_W-1:0] shot_idx;
  logic [ACC_W-1:0] acc;
  logic [GAP_W-1:0] gap_cnt;

  logic             tmr_clear;
  logic             tmr_enable;
  logic [CNT_W-1:0] tmr_count;
  logic             tmr_expired;

  logic             start;
  logic             fire_last;
  logic             gap_last;
  logic             last_shot;
  logic [ACC_W-1:0] acc_sum;

  // Round-trip counter: runs only while firing or waiting for the echo
  laser_shot_timer #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) u_shot_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmr_clear),
    .enable  (tmr_enable),
    .count   (tmr_count),
    .expired (tmr_expired)
  );

  // Sequencer decode: timer control, edge detect and end-of-phase flags
  always_comb begin
    tmr_enable = (state == ST_FIRE) || (state == ST_WAIT);
    tmr_clear  = !tmr_enable;
    // btn_armed blocks a press held across reset from looking like an edge
    start      = btn && !btn_q && btn_armed;
    fire_last  = (tmr_count == CNT_W'(PULSE_LEN - 1));
    gap_last   = (gap_cnt == GAP_W'(GAP_LEN - 1));
    last_shot  = (shot_idx == IDX_W'(NSHOTS - 1));
    acc_sum    = acc + ACC_W'(tmr_count);
  end

  // Measurement FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      btn_q       <= 1'b0;
      btn_armed   <= 1'b0;
      shot_idx    <= '0;
      acc         <= '0;
      gap_cnt     <= '0;
      act_laser   <= 1'b0;
      data        <= '0;
      valid       <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      btn_q       <= btn;
      if (!btn) begin
        btn_armed <= 1'b1;
      end
      valid       <= 1'b0;
      timeout_err <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_FIRE;
            shot_idx  <= '0;
            acc       <= '0;
            act_laser <= 1'b1;
            busy      <= 1'b1;
          end
        end

        ST_FIRE: begin
          if (fire_last) begin
            state     <= ST_WAIT;
            act_laser <= 1'b0;
          end
        end

        ST_WAIT: begin
          // An echo on the threshold cycle still counts as a good shot
          if (laser_reflect) begin
            acc <= acc_sum;
            if (last_shot) begin
              state <= ST_DONE;
              data  <= CNT_W'(acc_sum >> SHOTS_LOG2);
              valid <= 1'b1;
            end else begin
              state    <= ST_GAP;
              shot_idx <= shot_idx + IDX_W'(1);
              gap_cnt  <= '0;
            end
          end else if (tmr_expired) begin
            state       <= ST_ERR;
            acc         <= '0;
            shot_idx    <= '0;
            timeout_err <= 1'b1;
          end
        end

        ST_GAP: begin
          if (gap_last) begin
            state     <= ST_FIRE;
            act_laser <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end

        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end

        ST_ERR: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state     <= ST_IDLE;
          act_laser <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_laser_range_avg.sv
// Scoreboard bench for laser_range_avg: the driver queues the expected
// outcome of each measurement, a monitor checks every valid/timeout_err pulse.
module tb_laser_range_avg;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned TIMEOUT = 20;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             btn = 1'b0;
  logic             laser_reflect = 1'b0;
  logic             act_laser;
  logic [CNT_W-1:0] data;
  logic             valid;
  logic             timeout_err;
  logic             busy;

  always #5 clk = ~clk;

  laser_range_avg #(
    .CNT_W      (CNT_W),
    .SHOTS_LOG2 (2),
    .PULSE_LEN  (1),
    .GAP_LEN    (1),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .btn           (btn),
    .laser_reflect (laser_reflect),
    .act_laser     (act_laser),
    .data          (data),
    .valid         (valid),
    .timeout_err   (timeout_err),
    .busy          (busy)
  );

  typedef struct {
    bit          is_err;
    int unsigned data;
    int unsigned shots;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned last_data = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: counts laser strobes and checks each result pulse against the queue
  initial begin : monitor
    int   act_count;
    logic act_prev;
    exp_t e;
    act_count = 0;
    act_prev  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        act_count = 0;
        act_prev  = 1'b0;
      end else begin
        if (act_laser && !act_prev) act_count++;
        act_prev = act_laser;
        if (valid || timeout_err) begin
          check("valid_err_exclusive", longint'(valid && timeout_err), 0);
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output: valid=%0b timeout_err=%0b data=%0d with nothing expected",
                     valid, timeout_err, data);
          end else begin
            e = exp_q.pop_front();
            check("result_kind_err", longint'(timeout_err), longint'(e.is_err));
            check("result_data", longint'(data), longint'(e.data));
            check("result_shots", longint'(act_count), longint'(e.shots));
          end
          act_count = 0;
        end
      end
    end
  end

  task automatic wait_act(output bit ok);
    int t;
    t  = 0;
    ok = 1'b0;
    while (t < 200) begin
      @(negedge clk);
      t++;
      if (act_laser) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL act_wait: act_laser stayed 0 for 200 cycles, expected 1");
    end
  endtask

  // One shot: echo arrives while the counter reads n (n>=3 when spurious)
  task automatic shot(input int n, input bit spurious, input bit no_reflect);
    bit ok;
    wait_act(ok);
    if (!ok) return;
    if (no_reflect) begin
      repeat (TIMEOUT + 1) @(negedge clk);
      check("timeout_err_at_limit", longint'(timeout_err), 1);
      check("valid_low_on_timeout", longint'(valid), 0);
      return;
    end
    if (spurious) begin
      laser_reflect = 1'b1;         // echo during FIRE: must be ignored
      @(posedge clk);
      #1 laser_reflect = 1'b0;
      btn = 1'b0;                   // re-press while busy: must be ignored
      @(posedge clk);
      #1 btn = 1'b1;
      repeat (n - 2) @(posedge clk);
    end else begin
      repeat (n) @(posedge clk);
    end
    #1 laser_reflect = 1'b1;
    @(posedge clk);
    if (spurious) begin
      @(posedge clk);               // echo still high in GAP/DONE: ignored
    end
    #1 laser_reflect = 1'b0;
  endtask

  task automatic measure(input int c0, input int c1, input int c2, input int c3,
                         input int unsigned exp_data, input bit spurious, input int err_shot);
    int   c[4];
    exp_t e;
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    @(posedge clk);
    #1 btn = 1'b0;
    repeat (2) @(posedge clk);
    #1 btn = 1'b1;
    e.is_err = (err_shot >= 0);
    e.data   = e.is_err ? last_data : exp_data;
    e.shots  = e.is_err ? int'(err_shot + 1) : 4;
    exp_q.push_back(e);
    last_data = e.data;
    for (int i = 0; i < 4; i++) begin
      if (err_shot == i) begin
        shot(0, spurious, 1'b1);
        break;
      end
      shot(c[i], spurious, 1'b0);
    end
    repeat (5) @(posedge clk);
  endtask

  initial begin : driver
    bit ok;
    bit stray;
    int t;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_act_laser", longint'(act_laser), 0);
    check("reset_data", longint'(data), 0);
    check("reset_valid", longint'(valid), 0);
    check("reset_timeout_err", longint'(timeout_err), 0);
    check("reset_busy", longint'(busy), 0);

    // Basic average, then btn held: no second measurement
    measure(10, 12, 14, 16, 13, 1'b0, -1);
    stray = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (busy || act_laser) stray = 1'b1;
    end
    check("held_btn_single_start", longint'(stray), 0);

    // Truncating average
    measure(10, 10, 10, 11, 10, 1'b0, -1);

    // Shot 2 never echoes: abort, data keeps 10
    measure(8, 0, 0, 0, 0, 1'b0, 1);

    // Echo while idle must do nothing
    @(posedge clk);
    #1 laser_reflect = 1'b1;
    repeat (3) @(posedge clk);
    #1 laser_reflect = 1'b0;

    // Spurious echoes in FIRE/GAP and btn re-presses while busy
    measure(10, 12, 14, 16, 13, 1'b1, -1);

    // Echo exactly on the timeout count is accepted: (20+4+4+4)/4 = 8
    measure(20, 4, 4, 4, 8, 1'b0, -1);

    // Reset in WAIT of shot 3 with btn held high
    @(posedge clk);
    #1 btn = 1'b0;
    repeat (2) @(posedge clk);
    #1 btn = 1'b1;
    shot(10, 1'b0, 1'b0);
    shot(10, 1'b0, 1'b0);
    wait_act(ok);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_act_laser", longint'(act_laser), 0);
    check("midrst_data", longint'(data), 0);
    check("midrst_valid", longint'(valid), 0);
    check("midrst_timeout_err", longint'(timeout_err), 0);
    check("midrst_busy", longint'(busy), 0);
    last_data = 0;
    stray = 1'b0;
    repeat (30) begin
      @(negedge clk);
      if (busy || act_laser) stray = 1'b1;
    end
    check("no_start_btn_held_over_reset", longint'(stray), 0);

    // Fresh press after release works: (5+6+7+9)/4 = 6
    measure(5, 6, 7, 9, 6, 1'b0, -1);

    t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard_drained", longint'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
